// File: rtl/core_output_collector_if.sv
// Core-result and output-stream bundle for the output collector.
// The collector attaches to the slave modport; the producer/consumer side to master.
interface core_output_collector_if #(
  parameter int N_CORES = 22,
  parameter int DATA_W  = 31,
  parameter int IDX_W   = 5,
  parameter int LVL_W   = 5
);
  logic [N_CORES*DATA_W-1:0] core_data;
  logic [N_CORES-1:0]        core_en;
  logic signed [DATA_W-1:0]  out_data;
  logic [IDX_W-1:0]          out_idx;
  logic                      out_valid;
  logic                      out_ready;
  logic [LVL_W-1:0]          fifo_level;
  logic [N_CORES-1:0]        overrun;

  modport master (
    output core_data, core_en, out_ready,
    input  out_data, out_idx, out_valid, fifo_level, overrun
  );

  modport slave (
    input  core_data, core_en, out_ready,
    output out_data, out_idx, out_valid, fifo_level, overrun
  );
endinterface

// File: rtl/core_output_collector.sv
// Collects per-core result strobes into one-entry holds, drains them round-robin
// into a tagged first-word-fall-through FIFO with a valid/ready output.
module core_output_collector #(
  parameter int N_CORES    = 22,
  parameter int DATA_W     = 31,
  parameter int IDX_W      = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input logic clk,
  input logic rst,
  core_output_collector_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_CORES) s = s - N_CORES;
    return IDX_W'(s);
  endfunction

  logic [N_CORES-1:0]       r_hold_vld_p0;
  logic signed [DATA_W-1:0] r_hold_data_p0 [N_CORES];
  logic [N_CORES-1:0]       r_overrun;
  logic [IDX_W-1:0]         r_rr_ptr;

  logic signed [DATA_W-1:0] r_mem_data_p1 [FIFO_DEPTH];
  logic [IDX_W-1:0]         r_mem_idx_p1  [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [LVL_W-1:0]         r_level;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_can_push;
  logic                     w_gnt_vld;
  logic [IDX_W-1:0]         w_gnt_idx;
  logic [N_CORES-1:0]       w_gnt_oh;
  logic [IDX_W-1:0]         w_rr_nxt;

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop      = !w_empty && bus.out_ready;
  // A full FIFO can still accept a push when its head leaves in the same cycle.
  assign w_can_push = !w_full || w_pop;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    if (w_can_push) begin
      for (int k = 0; k < N_CORES; k++) begin
        if (!w_gnt_vld && r_hold_vld_p0[rr_index(r_rr_ptr, k)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = rr_index(r_rr_ptr, k);
        end
      end
    end
    if (w_gnt_vld) w_gnt_oh[w_gnt_idx] = 1'b1;
  end

  assign w_rr_nxt = (w_gnt_idx == IDX_W'(N_CORES - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

  // Stage p0: per-core holding registers, overrun flags and arbiter pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_vld_p0 <= '0;
      r_overrun     <= '0;
      r_rr_ptr      <= '0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (bus.core_en[i] && (!r_hold_vld_p0[i] || w_gnt_oh[i])) begin
          r_hold_vld_p0[i] <= 1'b1;
        end else if (w_gnt_oh[i]) begin
          r_hold_vld_p0[i] <= 1'b0;
        end
        if (bus.core_en[i] && r_hold_vld_p0[i] && !w_gnt_oh[i]) begin
          r_overrun[i] <= 1'b1;
        end
      end
      if (w_gnt_vld) r_rr_ptr <= w_rr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CORES; i++) begin
      if (bus.core_en[i] && (!r_hold_vld_p0[i] || w_gnt_oh[i])) begin
        r_hold_data_p0[i] <= bus.core_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: output FIFO; the arbiter grant is the push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_gnt_vld) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_gnt_vld, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt_vld) begin
      r_mem_data_p1[r_wr_ptr] <= r_hold_data_p0[w_gnt_idx];
      r_mem_idx_p1[r_wr_ptr]  <= w_gnt_idx;
    end
  end

  assign bus.out_valid  = !w_empty;
  assign bus.out_data   = w_empty ? '0 : r_mem_data_p1[r_rd_ptr];
  assign bus.out_idx    = w_empty ? '0 : r_mem_idx_p1[r_rd_ptr];
  assign bus.fifo_level = r_level;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_core_output_collector.sv
// Randomized and directed bench for core_output_collector against a queue-based
// reference model of the hold/round-robin/FIFO rules.
module tb_core_output_collector;
  localparam int N = 22, DW = 31, IW = 5, DEPTH = 16, LW = 5;
  localparam int VW = 1 + IW + DW + LW + N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_output_collector_if #(.N_CORES(N), .DATA_W(DW), .IDX_W(IW), .LVL_W(LW)) bus ();

  core_output_collector #(.N_CORES(N), .DATA_W(DW), .IDX_W(IW), .FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [IW-1:0]        idx;
    logic signed [DW-1:0] d;
  } ent_t;

  ent_t                 m_q[$];
  logic signed [DW-1:0] m_hd[N];
  bit                   m_hv[N];
  int                   m_rr;
  logic [N-1:0]         m_ovr;
  int checks = 0, errors = 0;

  function automatic logic [VW-1:0] exp_vec();
    ent_t h;
    logic v;
    v = (m_q.size() > 0);
    h = v ? m_q[0] : '0;
    return {v, h.idx, h.d, LW'(m_q.size()), m_ovr};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.out_valid, bus.out_idx, bus.out_data, bus.fifo_level, bus.overrun};
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < N; i++) m_hv[i] = 0;
    m_rr  = 0;
    m_ovr = '0;
  endtask

  task automatic clear_inputs();
    bus.core_en   = '0;
    bus.core_data = '0;
  endtask

  task automatic set_core(input int i, input logic signed [DW-1:0] v);
    bus.core_data[i*DW +: DW] = v;
    bus.core_en[i] = 1'b1;
  endtask

  // Advance model and DUT by one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    int  pre, g;
    bit  pop, canpush;
    pre     = m_q.size();
    pop     = (pre > 0) && bus.out_ready;
    canpush = (pre < DEPTH) || pop;
    g = -1;
    if (canpush) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_hv[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back('{idx: IW'(g), d: m_hd[g]});
      m_hv[g] = 0;
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.core_en[i]) begin
        if (!m_hv[i]) begin
          m_hd[i] = bus.core_data[i*DW +: DW];
          m_hv[i] = 1;
        end else begin
          m_ovr[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", obs_vec());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_simultaneous();
    int seen_i[$];
    int seen_d[$];
    bus.out_ready = 1'b1;
    set_core(0, 100);
    set_core(7, 200);
    set_core(21, 300);
    tick();
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL simul_cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (bus.out_valid) begin
        seen_i.push_back(int'(bus.out_idx));
        seen_d.push_back(int'(bus.out_data));
      end
      tick();
    end
    checks++;
    if (seen_i.size() != 3 || seen_i[0] != 0 || seen_i[1] != 7 || seen_i[2] != 21 ||
        seen_d[0] != 100 || seen_d[1] != 200 || seen_d[2] != 300) begin
      errors++;
      $display("FAIL simul_order: got %0d entries idx %p data %p want idx 0,7,21 data 100,200,300",
               seen_i.size(), seen_i, seen_d);
    end
  endtask

  task automatic test_single();
    logic [IW+DW:0] want;
    bus.out_ready = 1'b1;
    set_core(3, -5);
    tick();
    clear_inputs();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_e0: valid got %b want 0", bus.out_valid);
    end
    tick();
    want = {1'b1, 5'd3, 31'(-5)};
    checks++;
    if ({bus.out_valid, bus.out_idx, bus.out_data} !== want) begin
      errors++;
      $display("FAIL single_e1: got %h want %h", {bus.out_valid, bus.out_idx, bus.out_data}, want);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.overrun !== '0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL single_e2: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fairness();
    int seq[$];
    bit ok;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      clear_inputs();
      if (c % 2 == 0 && c < 16) begin
        set_core(2, $urandom);
        set_core(5, $urandom);
      end
      if (bus.out_valid) seq.push_back(int'(bus.out_idx));
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fair_cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
    ok = (seq.size() >= 14);
    for (int k = 0; k < seq.size(); k++) begin
      if (seq[k] != 2 && seq[k] != 5) ok = 0;
      if (k > 0 && seq[k] == seq[k-1]) ok = 0;
    end
    checks++;
    if (!ok || bus.overrun[2] !== 1'b0 || bus.overrun[5] !== 1'b0) begin
      errors++;
      $display("FAIL fair_alternate: got seq %p ovr2=%b ovr5=%b want alternating 2/5, no overrun",
               seq, bus.overrun[2], bus.overrun[5]);
    end
  endtask

  task automatic test_full();
    logic signed [DW-1:0] a, b;
    int seen_i[$];
    int seen_d[$];
    bit dup;
    logic [N-1:0] mask;
    a = DW'($urandom);
    b = DW'($urandom);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) set_core(i, DW'(1000 + i));
    tick();
    clear_inputs();
    repeat (18) tick();
    checks++;
    if (bus.fifo_level !== LW'(16) || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL full_level: got %h want level 16 / %h", obs_vec(), exp_vec());
    end
    set_core(16, a);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (bus.fifo_level !== LW'(16) || bus.overrun[16] !== 1'b0) begin
      errors++;
      $display("FAIL full_held: got level %0d ovr16 %b want 16 0", bus.fifo_level, bus.overrun[16]);
    end
    set_core(16, b);
    tick();
    clear_inputs();
    checks++;
    if (bus.overrun[16] !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL full_overrun: got %h want ovr16=1 / %h", obs_vec(), exp_vec());
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) begin
        seen_i.push_back(int'(bus.out_idx));
        seen_d.push_back(int'(bus.out_data));
      end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_drain_cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    mask = '0;
    dup = 0;
    for (int k = 0; k < 16 && k < seen_i.size(); k++) begin
      if (mask[seen_i[k]] || seen_i[k] > 15 || seen_d[k] != 1000 + seen_i[k]) dup = 1;
      mask[seen_i[k]] = 1'b1;
    end
    checks++;
    if (seen_i.size() != 17 || dup || seen_i[16] != 16 || seen_d[16] != int'(a)) begin
      errors++;
      $display("FAIL full_drain_order: got %0d entries idx %p last data %0d want 17, last idx 16 data %0d",
               seen_i.size(), seen_i, (seen_d.size() > 16) ? seen_d[16] : -1, a);
    end
  endtask

  task automatic test_refill_same_cycle();
    logic signed [DW-1:0] x, y;
    int seen_i[$];
    int seen_d[$];
    x = DW'($urandom);
    y = DW'($urandom);
    bus.out_ready = 1'b1;
    set_core(4, x);
    tick();
    clear_inputs();
    set_core(4, y);
    tick();
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      if (bus.out_valid) begin
        seen_i.push_back(int'(bus.out_idx));
        seen_d.push_back(int'(bus.out_data));
      end
      tick();
    end
    checks++;
    if (seen_i.size() != 2 || seen_i[0] != 4 || seen_i[1] != 4 || seen_d[0] != int'(x) ||
        seen_d[1] != int'(y) || bus.overrun[4] !== 1'b0) begin
      errors++;
      $display("FAIL refill: got idx %p data %p ovr4 %b want 4,4 data %0d,%0d ovr 0",
               seen_i, seen_d, bus.overrun[4], x, y);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      if (c < 350) begin
        for (int i = 0; i < N; i++) if ($urandom_range(29) == 0) set_core(i, DW'($urandom));
      end
      bus.out_ready = ($urandom_range(9) < 7) || (c >= 350);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) set_core(i, DW'(i + 50));
    tick();
    clear_inputs();
    repeat (9) tick();
    checks++;
    if (bus.fifo_level !== LW'(9) || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL rstmid_fill: got %h want level 9 / %h", obs_vec(), exp_vec());
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got %h want 0", obs_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_holds_cleared_cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    set_core(1, 7);
    tick();
    clear_inputs();
    tick();
    checks++;
    if ({bus.out_valid, bus.out_idx, bus.out_data} !== {1'b1, 5'd1, 31'sd7} || bus.overrun !== '0) begin
      errors++;
      $display("FAIL rstmid_after: got %h want valid idx1 data7", obs_vec());
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_fairness();
    test_full();
    test_refill_same_cycle();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_output_collector.md
Name: core_output_collector

Overview:
- Downstream of the multicore array; consumes the per-core result strobes (data + enable) from all cores.
- Merges them into a single ordered, tagged output stream for the file writer / host link.
- Cores cannot be back-pressured, so each core gets a one-entry holding register.
- A round-robin arbiter drains the holding registers into a first-word-fall-through FIFO with a valid/ready output.

Parameters:
- N_CORES, 22, number of core result ports.
- DATA_W, 31, signed result width per core.
- IDX_W, 5, width of the core-index tag; must satisfy 2**IDX_W >= N_CORES.
- FIFO_DEPTH, 16, output FIFO entries; power of two.
- LVL_W, 5, FIFO level width; holds the value FIFO_DEPTH.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- core_data  in  N_CORES*DATA_W  flattened core results; core i occupies bits [i*DATA_W +: DATA_W].
- core_en  in  N_CORES  per-core single-cycle result strobe.
- out_data  out  DATA_W  FIFO head data (signed).
- out_idx  out  IDX_W  core index of the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head this cycle.
- fifo_level  out  LVL_W  number of occupied FIFO entries.
- overrun  out  N_CORES  sticky per-core flag: a result was dropped.

Behaviour:
- Reset is asynchronous and active-high, and may be asserted at any time, including mid-operation. It clears:
  - all hold_valid bits;
  - all FIFO pointers, so out_valid=0 and fifo_level=0;
  - the RR pointer to 0;
  - overrun to 0.
  - out_data and out_idx read 0 while the FIFO is empty after reset.
  - Entries in flight are discarded; there is no partial output.
- Capture, core i:
  - On an edge with core_en[i]=1, hold_data[i] is loaded from core i's slice and hold_valid[i] is set.
- Arbitration (combinational grant, registered effect):
  - Eligible = hold_valid AND (FIFO not full OR a pop occurs this cycle).
  - Grant goes to the first index with hold_valid set, searching from rr_ptr upward and wrapping at N_CORES-1 to 0.
  - At most one grant per cycle.
  - On a grant g: push {g, hold_data[g]} into the FIFO, clear hold_valid[g], and set rr_ptr <= (g+1) mod N_CORES.
  - With no grant, rr_ptr holds.
- Simultaneous grant and core_en on the same core:
  - The granted entry is pushed.
  - The new data is loaded and hold_valid stays 1.
  - No overrun.
- Overrun:
  - core_en[i]=1 while hold_valid[i]=1 and core i is not granted that cycle → the new sample is dropped, the held data is kept, and overrun[i] is set.
  - overrun is cleared only by rst.
- FIFO pop and push rules:
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle: fifo_level is unchanged. This is allowed when full.
  - Push while empty: the entry appears on out_* after that edge (fall-through).
  - Push only when not full or when popping; the grant rule guarantees this, so the FIFO never overflows.
  - Pop while empty is impossible because out_valid=0.
- Latency, empty system:
  - core_en at edge E0 → held after E0 → granted at E1 → out_valid=1 after E1. Two edges total.
- Ordering:
  - Results from a single core leave in strict arrival order.
  - Across cores, order is round-robin order of the holding registers.
- Widths:
  - fifo_level ranges 0..FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
  - Data passes through unmodified, with sign preserved.
- Throughput: at most one result per cycle. Sustained aggregate core_en rate above 1/cycle produces overruns by design.

Test Plan:
- Single result: after reset, core_en[3]=1 with data=-5; out_ready=1 → out_valid rises after the second edge with out_data=-5, out_idx=3, for exactly 1 cycle; overrun=0.
- Simultaneous strobes: core_en[0], [7] and [21] all =1 in one cycle, data 100/200/300; out_ready=1 → outputs in 3 consecutive cycles, idx 0,7,21; rr_ptr ends at 0 (wrap).
- Fairness: cores 2 and 5 strobe every 2 cycles, so their holds are always pending → grants alternate 2,5,2,5; neither core sets overrun.
- Backpressure/full: out_ready=0; 16 cores strobe once each, indices 0..15 → fifo_level=16. Core 16 strobes → stays held. Core 16 strobes again → overrun[16]=1. Raise out_ready → the 16 FIFO entries drain, then idx 16 with the first-strobe data.
- Grant/refill same cycle: hold[4] pending, FIFO not full, core_en[4]=1 in the grant cycle → both samples are delivered in order; overrun[4]=0.
- Reset mid-operation: fifo_level=9 with holds pending; assert rst between edges → out_valid, fifo_level, overrun and hold_valid clear immediately; after release, core_en[1]=7 is delivered normally with idx 1.
